button_conditioner: RTL and testbench

Conditions one raw mechanical push-button into clean single-cycle event pulses for the front-panel counter logic. It synchronises the asynchronous pin, debounces it with a stable-count filter, emits one pulse per debounced press, and optionally auto-repeats while the button is held. One instance per button sits directly upstream of the segment display counter; its `button_out` drives that counter's increment or decrement enable.

---
 rtl/panel_pkg.sv | 30 +++
 rtl/debounce_filter.sv | 75 +++++++
 rtl/button_conditioner.sv | 136 +++++++++++++
 tb/tb_button_conditioner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/panel_pkg.sv
// ---------------------------------------------------------------------------
// panel_pkg
//   Shared definitions for the front-panel blocks (button conditioners and
//   the segment display counter).
//   - btn_state_t : event FSM state encoding used by button_conditioner.
//   - DEF_*       : default timing constants, in system clock cycles.
//   - width_of    : counter width needed to hold 0..n-1 (never below 1 bit).
//   - max_of      : larger of two integers, for sizing a shared timer.
// ---------------------------------------------------------------------------
package panel_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES     = 50000;
    localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
    localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/debounce_filter.sv
// ---------------------------------------------------------------------------
// debounce_filter
//   Synchronises a raw asynchronous button pin and filters contact bounce
//   with a stable-count filter. The debounced level only toggles after the
//   synchronised input has disagreed with it for DEBOUNCE_CYCLES consecutive
//   cycles; any glitch back to the current level restarts the count.
//
// Parameters
//   DEBOUNCE_CYCLES : cycles of stable disagreement before toggling (>= 1)
//   ACTIVE_LOW      : 1 inverts the pin so that a low level means pressed
//
// Ports
//   clk    in   system clock
//   rst    in   synchronous active-high reset
//   button in   raw asynchronous pin
//   level  out  registered debounced pressed level
//   rise   out  combinational: level goes 0->1 at the next clock edge
// ---------------------------------------------------------------------------
module debounce_filter
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic level,
    output logic rise
);

    localparam int             CNT_W    = width_of(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;   // synchronised input "s"
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;

    logic w_in;
    logic w_differ;
    logic w_done;

    // Inversion sits ahead of the first flop so both flops, and their reset
    // value of 0, are always in "pressed = 1" terms.
    assign w_in     = button ^ ACTIVE_LOW;
    assign w_differ = (r_sync2 != r_level);
    assign w_done   = w_differ && (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync1 <= w_in;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign level = r_level;
    // Announced one cycle early so the top can register its press pulse in
    // the same edge that raises the debounced level.
    assign rise  = w_done && r_sync2;

endmodule

// File: rtl/button_conditioner.sv
// ---------------------------------------------------------------------------
// button_conditioner
//   Turns one raw push-button into clean single-cycle event pulses: one pulse
//   per debounced press and, optionally, auto-repeat pulses while held.
//   Drives the increment/decrement enable of the segment display counter.
//
// Parameters
//   DEBOUNCE_CYCLES     : debounce stable-count length (>= 1)
//   REPEAT_ENABLE       : 1 enables auto-repeat, 0 gives one pulse per press
//   REPEAT_DELAY_CYCLES : press pulse to first repeat pulse (>= 2)
//   REPEAT_RATE_CYCLES  : spacing of subsequent repeat pulses (>= 2)
//   ACTIVE_LOW          : 1 means a low pin level is pressed
//
// Ports
//   clk           in   system clock
//   rst           in   synchronous active-high reset
//   button        in   raw asynchronous pin
//   button_out    out  registered one-cycle event pulse (press or repeat)
//   button_level  out  registered debounced pressed level
//   repeat_active out  registered, high while in the REPEAT state
// ---------------------------------------------------------------------------
module button_conditioner
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
    parameter bit REPEAT_ENABLE       = 1'b1,
    parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
    parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
    parameter bit ACTIVE_LOW          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic button_out,
    output logic button_level,
    output logic repeat_active
);

    localparam int TMR_W = width_of(max_of(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
    localparam logic [TMR_W-1:0] TMR_DELAY_LAST = TMR_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_RATE_LAST  = TMR_W'(REPEAT_RATE_CYCLES - 1);

    logic w_level;
    logic w_rise;

    btn_state_t       r_state;
    logic [TMR_W-1:0] r_timer;
    logic             r_out;
    logic             r_rep;

    btn_state_t       w_state_nxt;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_pulse;

    debounce_filter #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_debounce (
        .clk    (clk),
        .rst    (rst),
        .button (button),
        .level  (w_level),
        .rise   (w_rise)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_out   <= 1'b0;
            r_rep   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
            r_out   <= w_pulse;
            r_rep   <= (w_state_nxt == REPEAT);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = r_timer;
        w_pulse     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) begin
                    w_pulse     = 1'b1;
                    w_state_nxt = HOLD;
                    w_timer_nxt = '0;
                end
            end
            HOLD, REPEAT: begin
                if (!w_level) begin
                    // Release wins over any repeat pulse due this cycle. With
                    // a very short debounce a new press can already be rising
                    // here, so it is taken directly instead of being lost.
                    w_timer_nxt = '0;
                    if (w_rise) begin
                        w_pulse     = 1'b1;
                        w_state_nxt = HOLD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (r_state == HOLD) begin
                    // Without auto-repeat the timer stays parked at 0 so it
                    // can never wrap during a long hold.
                    if (REPEAT_ENABLE) begin
                        if (r_timer == TMR_DELAY_LAST) begin
                            w_pulse     = 1'b1;
                            w_state_nxt = REPEAT;
                            w_timer_nxt = '0;
                        end else begin
                            w_timer_nxt = r_timer + 1'b1;
                        end
                    end
                end else begin
                    if (r_timer == TMR_RATE_LAST) begin
                        w_pulse     = 1'b1;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_timer_nxt = '0;
            end
        endcase
    end

    assign button_out    = r_out;
    assign button_level  = w_level;
    assign repeat_active = r_rep;

endmodule

// File: tb/tb_button_conditioner.sv
// ---------------------------------------------------------------------------
// tb_button_conditioner
//   Two instances: u_dut1 (auto-repeat, active-high pin) and u_dut2 (no
//   repeat, active-low pin), both with DEBOUNCE=4, DELAY=10, RATE=3.
//   Expected pulse cycles are queued when stimulus is driven; a negedge
//   monitor pops and compares each observed pulse. cyc counts rising edges,
//   so a value sampled at a negedge belongs to the edge numbered cyc.
// ---------------------------------------------------------------------------
module tb_button_conditioner;

    logic clk = 1'b0;
    logic rst;
    logic btn1, btn2;
    logic out1, lvl1, ra1;
    logic out2, lvl2, ra2;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    int q1[$];
    int q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_conditioner #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_ENABLE       (1'b1),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_RATE_CYCLES  (3),
        .ACTIVE_LOW          (1'b0)
    ) u_dut1 (
        .clk           (clk),
        .rst           (rst),
        .button        (btn1),
        .button_out    (out1),
        .button_level  (lvl1),
        .repeat_active (ra1)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_ENABLE       (1'b0),
        .REPEAT_DELAY_CYCLES (10),
        .REPEAT_RATE_CYCLES  (3),
        .ACTIVE_LOW          (1'b1)
    ) u_dut2 (
        .clk           (clk),
        .rst           (rst),
        .button        (btn2),
        .button_out    (out2),
        .button_level  (lvl2),
        .repeat_active (ra2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Scoreboard monitors: every pulse must match the head of its queue.
    always @(negedge clk) begin
        if (out1 === 1'b1) begin
            if (q1.size() == 0) check_eq("dut1_unexpected_pulse", cyc, 32'hFFFF_FFFF);
            else                check_eq("dut1_pulse_cycle", cyc, q1.pop_front());
        end
        if (out2 === 1'b1) begin
            if (q2.size() == 0) check_eq("dut2_unexpected_pulse", cyc, 32'hFFFF_FFFF);
            else                check_eq("dut2_pulse_cycle", cyc, q2.pop_front());
        end
    end

    initial begin
        rst  = 1'b1;
        btn1 = 1'b1;   // held pressed through reset
        btn2 = 1'b1;   // active-low pin idle

        // Reset for edges 1..3, then release with the button still held.
        wait_until(3);
        check_eq("rst_out1", out1, 0);
        check_eq("rst_lvl1", lvl1, 0);
        check_eq("rst_ra1",  ra1,  0);
        check_eq("rst_out2", out2, 0);
        check_eq("rst_lvl2", lvl2, 0);
        check_eq("rst_ra2",  ra2,  0);
        rst = 1'b0;
        // Press pulse 6 edges later (P=9), repeats P+10+3k up to P+34.
        q1.push_back(9);
        for (int k = 0; k <= 8; k++) q1.push_back(19 + 3 * k);

        wait_until(8);  check_eq("lvl1_before_press", lvl1, 0);
        wait_until(9);  check_eq("lvl1_at_press", lvl1, 1);
        wait_until(18); check_eq("ra1_before_repeat", ra1, 0);
        wait_until(19); check_eq("ra1_first_repeat", ra1, 1);
        // Release 30 cycles after P; the repeat due at P+37 must be dropped.
        wait_until(39); btn1 = 1'b0;
        wait_until(44); check_eq("lvl1_still_high", lvl1, 1);
        wait_until(45); check_eq("lvl1_released", lvl1, 0);
                        check_eq("ra1_lags_release", ra1, 1);
        wait_until(46); check_eq("ra1_cleared", ra1, 0);

        // Bounce 1,0,1,1,0 then held: one pulse 6 edges after last rise.
        wait_until(60); btn1 = 1'b1;
        wait_until(61); btn1 = 1'b0;
        wait_until(62); btn1 = 1'b1;
        wait_until(64); btn1 = 1'b0;
        wait_until(65); btn1 = 1'b1;
        q1.push_back(71);
        wait_until(70); check_eq("bounce_lvl_low", lvl1, 0);
        wait_until(71); check_eq("bounce_lvl_high", lvl1, 1);
        // Release lands exactly when the first repeat is due (cycle 81).
        wait_until(74); btn1 = 1'b0;
        wait_until(79); check_eq("bounce_lvl_hold", lvl1, 1);
        wait_until(80); check_eq("bounce_lvl_rel", lvl1, 0);
        wait_until(81); check_eq("due_rel_ra1", ra1, 0);
                        check_eq("due_rel_out1", out1, 0);

        // Isolated 3-cycle pulse: one short of the debounce count.
        wait_until(100); btn1 = 1'b1;
        wait_until(103); btn1 = 1'b0;
        wait_until(106); check_eq("short_lvl_a", lvl1, 0);
        wait_until(110); check_eq("short_lvl_b", lvl1, 0);

        // Reset in the middle of auto-repeat.
        wait_until(120); btn1 = 1'b1;
        q1.push_back(126); q1.push_back(136); q1.push_back(139);
        wait_until(136); check_eq("pre_rst_ra1", ra1, 1);
        wait_until(140); rst = 1'b1;
        wait_until(141);
        check_eq("midrst_out1", out1, 0);
        check_eq("midrst_lvl1", lvl1, 0);
        check_eq("midrst_ra1",  ra1,  0);
        rst = 1'b0;
        q1.push_back(147); q1.push_back(157); q1.push_back(160);
        q1.push_back(163); q1.push_back(166);
        wait_until(156); check_eq("post_rst_ra1_low", ra1, 0);
        wait_until(157); check_eq("post_rst_ra1_high", ra1, 1);
        wait_until(161); btn1 = 1'b0;
        wait_until(167); check_eq("post_rst_ra1_rel", ra1, 1);
        wait_until(168); check_eq("post_rst_ra1_clr", ra1, 0);

        // No-repeat, active-low instance: pin low for 100 cycles.
        wait_until(200); btn2 = 1'b0;
        q2.push_back(206);
        wait_until(205); check_eq("dut2_lvl_before", lvl2, 0);
        for (int t = 206; t <= 300; t += 10) begin
            wait_until(t);
            check_eq("dut2_lvl_held", lvl2, 1);
            check_eq("dut2_ra_low", ra2, 0);
        end
        wait_until(300); btn2 = 1'b1;
        wait_until(306); check_eq("dut2_lvl_rel", lvl2, 0);

        wait_until(330);
        check_eq("q1_drained", q1.size(), 0);
        check_eq("q2_drained", q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
